// File: rtl/myp0_pkg.sv
// Shared MY-P0 definitions: interrupt controller state encoding and
// interrupt-related constants used across the processor front end.
package myp0_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2,
    VEC  = 2'd3
  } intc_state_t;

  localparam logic [31:0] IVT_BASE_DEFAULT = 32'h0000_0100;
  localparam logic [7:0]  DEV_ID_TIMER     = 8'h00;

endpackage

// File: rtl/interrupt_controller.sv
// Processor-side interrupt front end: gates the shared interrupt line with IE,
// runs the INTA handshake down the daisy chain and produces the vector address.
module interrupt_controller
  import myp0_pkg::*;
#(
  parameter logic [31:0] IVT_BASE  = IVT_BASE_DEFAULT,
  parameter int          ID_W      = 8,
  parameter int          INTA_HOLD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_line,
  input  logic        ie_set,
  input  logic        ie_clr,
  input  logic        ack_req,
  input  logic        vec_take,
  input  logic [31:0] dev_bus,
  output logic        ie,
  output logic        irq_pending,
  output logic        inta,
  output logic        vec_valid,
  output logic [31:0] vec_addr
);

  localparam int CNT_W = $clog2(INTA_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTA_HOLD - 1);

  intc_state_t      state_q, state_d;
  logic             ie_q, ie_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      vec_addr_q, vec_addr_d;
  logic             req;
  logic             ack_entry;

  // Only a driven 1 is a request; a floating line reads as idle.
  assign req = (int_line == 1'b1);

  // Bits above the device ID are don't-care on the shared bus.
  logic unused_bus;
  assign unused_bus = ^dev_bus[31:ID_W];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_addr_d = vec_addr_q;
    ack_entry  = 1'b0;
    unique case (state_q)
      IDLE: if (ie_q && req) state_d = PEND;
      PEND: begin
        if (ack_req) begin
          state_d   = ACK;
          cnt_d     = '0;
          ack_entry = 1'b1;
        end else if (ie_clr || !req) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The device had a full cycle of INTA to drive its ID; sample it now.
        if (cnt_q == CNT_LAST) begin
          vec_addr_d = IVT_BASE + 32'(dev_bus[ID_W-1:0]);
          state_d    = VEC;
        end
      end
      VEC: if (vec_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ACK entry masks further requests and beats a same-cycle EI.
  always_comb begin
    ie_d = ie_q;
    if (ack_entry || ie_clr) ie_d = 1'b0;
    else if (ie_set)         ie_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ie_q       <= 1'b0;
      cnt_q      <= '0;
      vec_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      cnt_q      <= cnt_d;
      vec_addr_q <= vec_addr_d;
    end
  end

  assign ie          = ie_q;
  assign irq_pending = (state_q == PEND);
  assign inta        = (state_q == ACK);
  assign vec_valid   = (state_q == VEC);
  assign vec_addr    = vec_addr_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a timer and one downstream
// device on the INTA chain; a second instance covers vector address wrap.
module tb_interrupt_controller;
  import myp0_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ie_set = 1'b0, ie_clr = 1'b0, ack_req = 1'b0, vec_take = 1'b0;
  logic        tmr_pend = 1'b0, dev2_pend = 1'b0;
  logic        int_line;
  logic [31:0] dev_bus = 32'hAAAA_AA77;
  logic        ie, irq_pending, inta, vec_valid;
  logic [31:0] vec_addr;
  logic        ie2, irq_pending2, inta2, vec_valid2;
  logic [31:0] vec_addr2;
  logic        tmr_inta_out;
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  interrupt_controller u_dut (
    .clk(clk), .rst(rst_n), .int_line(int_line), .ie_set(ie_set), .ie_clr(ie_clr),
    .ack_req(ack_req), .vec_take(vec_take), .dev_bus(dev_bus), .ie(ie),
    .irq_pending(irq_pending), .inta(inta), .vec_valid(vec_valid), .vec_addr(vec_addr)
  );

  interrupt_controller #(.IVT_BASE(32'hFFFF_FFFE)) u_dut_wrap (
    .clk(clk), .rst(rst_n), .int_line(int_line), .ie_set(ie_set), .ie_clr(ie_clr),
    .ack_req(ack_req), .vec_take(vec_take), .dev_bus(dev_bus), .ie(ie2),
    .irq_pending(irq_pending2), .inta(inta2), .vec_valid(vec_valid2), .vec_addr(vec_addr2)
  );

  // Device models: open-drain OR of requests, timer first on the chain.
  // A pending device drives its ID one cycle after seeing INTA; upper bus bits are junk.
  assign int_line     = tmr_pend | dev2_pend;
  assign tmr_inta_out = inta & ~tmr_pend;

  always @(posedge clk) begin
    if (inta && tmr_pend)              dev_bus <= {24'h5A5A5A, DEV_ID_TIMER};
    else if (tmr_inta_out && dev2_pend) dev_bus <= 32'hABCD_1203;
    else                                dev_bus <= 32'hAAAA_AA77;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic pend_seen;
    // Reset state
    #3;
    chk("rst_ie", 32'(ie), 0);
    chk("rst_pend", 32'(irq_pending), 0);
    chk("rst_inta", 32'(inta), 0);
    chk("rst_vvalid", 32'(vec_valid), 0);
    chk("rst_vaddr", vec_addr, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Basic flow with the timer
    ie_set = 1; tick(); ie_set = 0;
    chk("basic_ie_set", 32'(ie), 1);
    tmr_pend = 1; tick();
    chk("basic_pend", 32'(irq_pending), 1);
    chk("basic_pend_inta", 32'(inta), 0);
    ack_req = 1; tick(); ack_req = 0;
    chk("basic_inta1", 32'(inta), 1);
    chk("basic_ie_clr_ack", 32'(ie), 0);
    chk("basic_pend_off", 32'(irq_pending), 0);
    chk("basic_tmr_out", 32'(tmr_inta_out), 0);
    tick();
    chk("basic_inta2", 32'(inta), 1);
    chk("basic_vvalid_early", 32'(vec_valid), 0);
    tick();
    chk("basic_inta_done", 32'(inta), 0);
    chk("basic_vvalid", 32'(vec_valid), 1);
    chk("basic_vaddr", vec_addr, 32'h0000_0100);
    chk("basic_vaddr_wrap", vec_addr2, 32'hFFFF_FFFE);
    tmr_pend = 0; tick(2);
    chk("basic_vvalid_hold", 32'(vec_valid), 1);
    chk("basic_vaddr_hold", vec_addr, 32'h0000_0100);
    vec_take = 1; tick(); vec_take = 0;
    chk("basic_vtake", 32'(vec_valid), 0);
    chk("basic_ie_after", 32'(ie), 0);

    // Masking: line high with IE off never pends
    tmr_pend = 1; pend_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (irq_pending) pend_seen = 1;
    end
    chk("mask_100", 32'(pend_seen), 0);
    ie_set = 1; tick(); ie_set = 0;
    chk("mask_ie_edge", 32'(irq_pending), 0);
    tick();
    chk("mask_pend", 32'(irq_pending), 1);

    // Withdrawal by DI while pending
    ie_clr = 1; tick(); ie_clr = 0;
    chk("wd_pend", 32'(irq_pending), 0);
    chk("wd_ie", 32'(ie), 0);
    chk("wd_inta", 32'(inta), 0);
    tick(3);
    chk("wd_inta_later", 32'(inta), 0);
    chk("wd_idle", 32'(irq_pending), 0);

    // DI together with ack: ack wins
    ie_set = 1; tick(); ie_set = 0; tick();
    chk("wd2_pend", 32'(irq_pending), 1);
    ie_clr = 1; ack_req = 1; tick(); ie_clr = 0; ack_req = 0;
    chk("wd2_inta", 32'(inta), 1);
    chk("wd2_ie", 32'(ie), 0);
    tick(2);
    chk("wd2_vaddr", vec_addr, 32'h0000_0100);
    // vec_take on the first valid cycle
    vec_take = 1; tick(); vec_take = 0;
    chk("vt_first", 32'(vec_valid), 0);
    tmr_pend = 0;

    // Chained device ID 3, EI coincident with ACK entry
    dev2_pend = 1;
    ie_set = 1; tick(); ie_set = 0; tick();
    chk("ch_pend", 32'(irq_pending), 1);
    ie_set = 1; ack_req = 1; tick(); ie_set = 0; ack_req = 0;
    chk("ch_ie_ack_prio", 32'(ie), 0);
    chk("ch_tmr_out", 32'(tmr_inta_out), 1);
    tick(2);
    chk("ch_vvalid", 32'(vec_valid), 1);
    chk("ch_vaddr", vec_addr, 32'h0000_0103);
    chk("ch_vaddr_wrap", vec_addr2, 32'h0000_0001);
    vec_take = 1; tick(); vec_take = 0;
    dev2_pend = 0;

    // EI and DI together in IDLE
    ie_set = 1; ie_clr = 1; tick(); ie_set = 0; ie_clr = 0;
    chk("setclr_ie", 32'(ie), 0);

    // Withdrawal by line dropping
    ie_set = 1; tick(); ie_set = 0;
    tmr_pend = 1; tick();
    chk("drop_pend", 32'(irq_pending), 1);
    tmr_pend = 0; tick();
    chk("drop_idle", 32'(irq_pending), 0);

    // Asynchronous reset in the middle of ACK
    tmr_pend = 1; tick();
    ack_req = 1; tick(); ack_req = 0;
    chk("rstack_inta_pre", 32'(inta), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstack_inta", 32'(inta), 0);
    chk("rstack_ie", 32'(ie), 0);
    chk("rstack_pend", 32'(irq_pending), 0);
    chk("rstack_vvalid", 32'(vec_valid), 0);
    chk("rstack_vaddr", vec_addr, 32'h0);
    tmr_pend = 0;
    @(negedge clk); rst_n = 1'b1;
    tick(2);
    chk("post_rst_idle", 32'(inta), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
